// File: rtl/cp0_stall_ctrl.sv
// CP0 hazard stall controller: turns the mfc0/mtc0 EPC distance code
// into a timed PC/IF-ID hold with ID/EX bubbles, plus a stall counter.
module cp0_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cp0bubble,
    input  logic             pipe_freeze,
    input  logic             flush,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall;
    logic             start;

    // Codes 1/2 need more stall cycles than the detection cycle itself.
    assign start = (cp0bubble == 2'd1) || (cp0bubble == 2'd2);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = (cp0bubble != 2'd0) && !flush;
                if (start && !flush && !pipe_freeze) begin
                    state_d = STALL;
                    rem_d   = 2'd3 - cp0bubble;
                end
            end
            STALL: begin
                stall = !flush;
                if (flush) begin
                    state_d = IDLE;
                    rem_d   = 2'd0;
                end else if (!pipe_freeze) begin
                    rem_d = rem_q - 2'd1;
                    if (rem_q == 2'd1) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !pipe_freeze && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_stall     = stall;
    assign ifid_stall   = stall;
    assign idex_bubble  = stall;
    assign busy         = (state_q == STALL);
    assign stall_cycles = cnt_q;

endmodule

// File: doc/cp0_stall_ctrl.md
# cp0_stall_ctrl

Consumes the 2-bit CP0 hazard distance code produced by the CP0 hazard detector (`mfc0` in ID against an in-flight `mtc0` to EPC) and turns it into a timed stall sequence for the front of the pipeline. It holds PC and IF/ID, and injects bubbles into ID/EX, until the `mtc0` result has been committed to CP0. It also honours whole-pipeline freezes and exception/`eret` flushes, and keeps a saturating count of CP0-hazard stall cycles for performance monitoring.

## Interface
- `CNT_W`, default 16, width of the stall-cycle performance counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cp0bubble` input 2: hazard distance code.
  - 0 = no hazard.
  - 1 = `mtc0` EPC in EX.
  - 2 = `mtc0` EPC in MEM.
  - 3 = `mtc0` EPC in WR.
- `pipe_freeze` input 1: whole-pipeline freeze from another unit (memory wait); no stage advances while high.
- `flush` input 1: exception/`eret` flush of IF, ID and EX this cycle.
- `pc_stall` output 1: hold PC.
- `ifid_stall` output 1: hold the IF/ID register.
- `idex_bubble` output 1: load a NOP into ID/EX instead of the ID instruction.
- `busy` output 1: FSM is in STALL.
- `stall_cycles` output `CNT_W`: saturating count of cycles in which `pc_stall` was high and `pipe_freeze` was low.

## Operation
- Required total stall length for a detected hazard is 4 − `cp0bubble` cycles.
  - code 1 → 3 cycles; code 2 → 2 cycles; code 3 → 1 cycle.
  - The first stall cycle is the detection cycle itself.
- `stall` below means `pc_stall = ifid_stall = idex_bubble`; all three are always equal.
- Remaining-cycle counter `rem`, 2 bits.
- FSM states: IDLE, STALL.
- IDLE:
  - `stall` = (`cp0bubble` ≠ 0) & !`flush`. This output is combinational (Mealy), in the same cycle as detection.
  - Goes to STALL with `rem` = 3 − `cp0bubble` when all of these hold: `cp0bubble` ∈ {1,2}, !`flush`, !`pipe_freeze`.
  - Code 3 produces a single-cycle stall and stays in IDLE.
  - While `pipe_freeze` is high: no transition and `rem` untouched. The hazard remains visible because the pipeline does not move.
- STALL:
  - `stall` = !`flush`. `cp0bubble` is ignored; the detector's changing code as the `mtc0` advances must not retrigger or extend the stall.
  - `flush` high: go to IDLE and clear `rem`. Flush has priority over everything.
  - `pipe_freeze` high (and no flush): hold state and `rem`.
  - Otherwise: if `rem` = 1, go to IDLE; else `rem` −= 1.
- Back-to-back hazards: in the cycle after returning to IDLE, a nonzero `cp0bubble` is evaluated as a new hazard.
- `busy` = (state == STALL).
- `stall_cycles`:
  - Increments when `stall` & !`pipe_freeze`.
  - Saturates at 2^`CNT_W` − 1.
  - Cleared only by `rst`.
- Code 0 in STALL is legal and ignored. No illegal codes exist.

## Timing
- Reset values, at the first edge with `rst` high: state IDLE, `rem` 0, `stall_cycles` 0, `busy` 0.
- Outputs during and after reset: `pc_stall`, `ifid_stall` and `idex_bubble` follow the IDLE equations, so they are 0 when `cp0bubble` = 0.
- `rst` has priority over `flush` and `pipe_freeze`. Reset mid-STALL aborts the sequence at the next edge.
- Latency:
  - Stall asserts combinationally in the detection cycle (0 cycles).
  - It deasserts in the cycle after the last non-frozen STALL cycle.
- Frozen cycles extend the stall 1:1 and do not count toward the required length.
- Simultaneous `flush` and `pipe_freeze`: flush wins, and the FSM returns to IDLE.
- The counter update and the FSM update share the same edge. The counter sees pre-edge `stall`.

## Test plan
- **Code 1, no freeze:** `cp0bubble`=1 for one cycle, then 2, then 3, then 0.
  - Required: `stall` high for exactly 3 cycles starting in the detection cycle.
  - Required: `busy` high in cycles 2–3.
  - Required: `stall_cycles` = 3.
- **Code 3 only:** `cp0bubble`=3 for one cycle, then 0.
  - Required: `stall` high for exactly 1 cycle.
  - Required: `busy` never high.
  - Required: `stall_cycles` = 1.
- **Freeze mid-stall:** code 2 detected, then `pipe_freeze` high for 4 cycles during STALL.
  - Required: `stall` high for 6 cycles total.
  - Required: `rem` held during the freeze.
  - Required: `stall_cycles` = 2.
- **Flush mid-stall:** code 1 detected, `flush` high in the 2nd cycle.
  - Required: `stall` low in that cycle.
  - Required: state IDLE at the next edge.
  - Required: no further stall if `cp0bubble`=0.
- **Back-to-back and reset:**
  - Code 2 sequence, then a new code 1 the cycle after the return to IDLE. Required: 2 + 3 stall cycles with a one-cycle gap.
  - Then `rst` asserted in the middle of the second sequence. Required: all state 0 and `stall_cycles` = 0 after the edge.
- **Saturation:** `CNT_W`=4, with repeated code-1 hazards.
  - Required: `stall_cycles` stops at 15 and does not wrap to 0.
